pll_lock_sequencer: RTL and testbench
=====================================

// Module: pll_lock_sequencer
// PURPOSE
// - Supervises the 50 MHz-input FCCC PLL (outputs GL0, GL1, LOCK) from the free-running board clock.
// - Holds the GL0- and GL1-domain logic in reset until LOCK has been stable long enough, then releases those resets in order.
// - On loss of lock, re-asserts both resets and counts the event. Retries the PLL on lock timeout and flags a hard failure after MAX_RETRY timeouts.
// PARAMETERS
// - LOCK_STABLE_CYC  1000   consecutive lock_s-high cycles required before GL0 release (>=2)
// - LOCK_TIMEOUT_CYC 50000  cycles allowed in WAIT_LOCK before a timeout (>=2)
// - REL_GAP_CYC      16     cycles between the RST_GL0 release and the RST_GL1 release (>=1)
// - PLL_RST_CYC      32     PLL_RESET pulse width in cycles (>=1)
// - MAX_RETRY        3      timeouts allowed before entering FAIL (1..7)
// - CNT_W            16     width of the shared timer; must hold max(all *_CYC)
// PORTS
// - CLK            in   1  50 MHz board clock (the same net as the PLL CLK0 input)
// - RST            in   1  synchronous reset, active-high
// - LOCK           in   1  PLL LOCK, asynchronous to CLK
// - PLL_RESET      out  1  reset request to the PLL, active-high
// - RST_GL0        out  1  reset for the GL0 domain, active-high, CLK-synchronous
// - RST_GL1        out  1  reset for the GL1 domain, active-high, CLK-synchronous
// - READY          out  1  both domains released and lock good
// - TIMEOUT_ERR    out  1  sticky; FAIL reached
// - LOCK_LOSS_CNT  out  8  saturating count of lock losses after stability was reached
// - STATE          out  3  current FSM state encoding (debug)
// BEHAVIOUR
// - Clock and reset: one clock, CLK; reset RST is synchronous and active-high.
// - Reset values: state=PLL_RST, PLL_RESET=1, RST_GL0=1, RST_GL1=1, READY=0, TIMEOUT_ERR=0,
//   LOCK_LOSS_CNT=0, retry=0, timer=0, sync FFs=0.
// - Lock synchroniser: LOCK passes through 2 flip-flops to give lock_s (2-cycle latency). All decisions use lock_s only.
// - Outputs: all registered; each changes on the same edge as the state transition that causes it.
// - PLL_RST (0): PLL_RESET=1. On timer==PLL_RST_CYC-1 -> WAIT_LOCK, PLL_RESET<=0, timer<=0.
// - WAIT_LOCK (1): timer increments each cycle.
//   - If lock_s=1 -> STABLE, timer<=0.
//   - Else if timer==LOCK_TIMEOUT_CYC-1: retry++. If the new retry==MAX_RETRY -> FAIL; otherwise -> PLL_RST, timer<=0.
//   - If lock_s rises on the timeout cycle, lock wins.
// - STABLE (2): lock_s=0 -> WAIT_LOCK, timer<=0. No loss count; the timeout restarts.
//   lock_s=1 and timer==LOCK_STABLE_CYC-1 -> REL0, RST_GL0<=0, timer<=0.
// - REL0 (3): lock_s=0 -> WAIT_LOCK, RST_GL0<=1, LOCK_LOSS_CNT++.
//   timer==REL_GAP_CYC-1 -> RUN, RST_GL1<=0, READY<=1, retry<=0.
// - RUN (4): lock_s=0 -> WAIT_LOCK, RST_GL0<=1, RST_GL1<=1, READY<=0, LOCK_LOSS_CNT++, timer<=0.
// - FAIL (5): PLL_RESET=1, RST_GL0=1, RST_GL1=1, READY=0, TIMEOUT_ERR=1. Terminal until RST.
// - LOCK_LOSS_CNT: saturates at 8'hFF and never wraps. Cleared only by RST.
// - Latency: RST_GL0 falls LOCK_STABLE_CYC+2 edges after the first edge that samples LOCK=1.
//   RST_GL1 and READY follow REL_GAP_CYC edges later.
//   Resets re-assert 2 edges after the first edge that samples LOCK=0 in REL0 or RUN.
// - A LOCK glitch shorter than 1 cycle may be missed; this is acceptable.
// - Illegal STATE codes (6, 7) -> PLL_RST with resets asserted.
// - RST asserted mid-sequence returns to the reset values on the next edge. LOCK_LOSS_CNT is cleared.
// - RST_GL0/RST_GL1 are CLK-synchronous. Each GL domain re-synchronises its reset (async assert, sync deassert) locally.
// STRUCTURE
// - Package pll_seq_pkg:
//   - state encoding localparams S_PLL_RST..S_FAIL (3 bits)
//   - LOSS_W=8
// - Sub-module sync_2ff: single-bit 2-FF synchroniser with synchronous reset to 0, used for LOCK.
// - The FSM, shared timer, retry counter and loss counter live in this module.
// TESTING (parameter overrides: LOCK_STABLE_CYC=8, REL_GAP_CYC=4, LOCK_TIMEOUT_CYC=64, PLL_RST_CYC=4, MAX_RETRY=2)
// - Reset: RST=1 for 3 cycles, then 0 -> PLL_RESET=1 for exactly 4 cycles, then 0. RST_GL0=RST_GL1=1 and READY=0 throughout.
// - Clean lock: raise LOCK after PLL_RESET falls -> RST_GL0 falls 10 edges after LOCK is first sampled. RST_GL1 and READY rise/fall 4 edges later. LOCK_LOSS_CNT=0.
// - Unstable lock: LOCK high 5 cycles, then low 1, then high -> no release until 8 consecutive lock_s cycles. LOCK_LOSS_CNT stays 0.
// - Loss in RUN: drop LOCK -> both resets=1 and READY=0 two edges later. LOCK_LOSS_CNT=1.
//   Restore LOCK -> full release sequence repeats.
// - Timeout: LOCK held 0 -> PLL_RST, then a second 64-cycle wait -> FAIL with TIMEOUT_ERR=1 and PLL_RESET=1. The block stays there until RST.
// - Saturation: 260 loss/recover cycles -> LOCK_LOSS_CNT=8'hFF. Mid-RUN RST -> all outputs return to their reset values on the next edge.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL lock sequencer.
// State codes are fixed because STATE is exported for debug.
package pll_seq_pkg;

    localparam logic [2:0] S_PLL_RST   = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_STABLE    = 3'd2;
    localparam logic [2:0] S_REL0      = 3'd3;
    localparam logic [2:0] S_RUN       = 3'd4;
    localparam logic [2:0] S_FAIL      = 3'd5;

    localparam int LOSS_W = 8;

    typedef enum logic [2:0] {
        ST_PLL_RST   = S_PLL_RST,
        ST_WAIT_LOCK = S_WAIT_LOCK,
        ST_STABLE    = S_STABLE,
        ST_REL0      = S_REL0,
        ST_RUN       = S_RUN,
        ST_FAIL      = S_FAIL
    } state_t;

    function automatic logic [LOSS_W-1:0] sat_inc(
        input logic [LOSS_W-1:0] v
    );
        return (v == '1) ? v : v + LOSS_W'(1);
    endfunction

endpackage

// File: rtl/pll_lock_sequencer_if.sv
// PLL-side and domain-reset signals of the lock sequencer.
// master = sequencer, slave = PLL / board model.
interface pll_lock_sequencer_if;
    import pll_seq_pkg::*;

    logic              LOCK;
    logic              PLL_RESET;
    logic              RST_GL0;
    logic              RST_GL1;
    logic              READY;
    logic              TIMEOUT_ERR;
    logic [LOSS_W-1:0] LOCK_LOSS_CNT;
    logic [2:0]        STATE;

    modport master (
        input  LOCK,
        output PLL_RESET, RST_GL0, RST_GL1, READY,
        output TIMEOUT_ERR, LOCK_LOSS_CNT, STATE
    );

    modport slave (
        output LOCK,
        input  PLL_RESET, RST_GL0, RST_GL1, READY,
        input  TIMEOUT_ERR, LOCK_LOSS_CNT, STATE
    );

endinterface

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser with synchronous clear.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL supervisor: waits for stable lock, releases GL0 then GL1 resets,
// re-asserts on lock loss, retries the PLL and latches a hard failure.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int LOCK_STABLE_CYC  = 1000,
    parameter int LOCK_TIMEOUT_CYC = 50000,
    parameter int REL_GAP_CYC      = 16,
    parameter int PLL_RST_CYC      = 32,
    parameter int MAX_RETRY        = 3,
    parameter int CNT_W            = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    pll_lock_sequencer_if.master  bus
);

    localparam logic [CNT_W-1:0] T_PRST = CNT_W'(PLL_RST_CYC - 1);
    localparam logic [CNT_W-1:0] T_TO   = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] T_STB  = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] T_GAP  = CNT_W'(REL_GAP_CYC - 1);
    localparam logic [2:0]       R_MAX  = 3'(MAX_RETRY);

    state_t            state, state_n;
    logic [CNT_W-1:0]  timer, timer_n;
    logic [2:0]        retry, retry_n;
    logic [LOSS_W-1:0] loss, loss_n;
    logic              pll_q, pll_n;
    logic              gl0_q, gl0_n;
    logic              gl1_q, gl1_n;
    logic              rdy_q, rdy_n;
    logic              err_q, err_n;
    logic              lock_s;

    sync_2ff u_lock_sync (
        .clk (CLK),
        .rst (RST),
        .d   (bus.LOCK),
        .q   (lock_s)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_PLL_RST;
            timer <= '0;
            retry <= '0;
            loss  <= '0;
            pll_q <= 1'b1;
            gl0_q <= 1'b1;
            gl1_q <= 1'b1;
            rdy_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state <= state_n;
            timer <= timer_n;
            retry <= retry_n;
            loss  <= loss_n;
            pll_q <= pll_n;
            gl0_q <= gl0_n;
            gl1_q <= gl1_n;
            rdy_q <= rdy_n;
            err_q <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        timer_n = timer + CNT_W'(1);
        retry_n = retry;
        loss_n  = loss;
        pll_n   = pll_q;
        gl0_n   = gl0_q;
        gl1_n   = gl1_q;
        rdy_n   = rdy_q;
        err_n   = err_q;
        unique case (state)
            ST_PLL_RST: begin
                pll_n = 1'b1;
                if (timer == T_PRST) begin
                    state_n = ST_WAIT_LOCK;
                    pll_n   = 1'b0;
                    timer_n = '0;
                end
            end
            ST_WAIT_LOCK: begin
                // lock takes priority over a coincident timeout
                if (lock_s) begin
                    state_n = ST_STABLE;
                    timer_n = '0;
                end else if (timer == T_TO) begin
                    retry_n = retry + 3'd1;
                    timer_n = '0;
                    pll_n   = 1'b1;
                    if (retry_n == R_MAX) begin
                        state_n = ST_FAIL;
                        err_n   = 1'b1;
                    end else begin
                        state_n = ST_PLL_RST;
                    end
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_n = ST_WAIT_LOCK;
                    timer_n = '0;
                end else if (timer == T_STB) begin
                    state_n = ST_REL0;
                    gl0_n   = 1'b0;
                    timer_n = '0;
                end
            end
            ST_REL0: begin
                if (!lock_s) begin
                    state_n = ST_WAIT_LOCK;
                    gl0_n   = 1'b1;
                    loss_n  = sat_inc(loss);
                    timer_n = '0;
                end else if (timer == T_GAP) begin
                    state_n = ST_RUN;
                    gl1_n   = 1'b0;
                    rdy_n   = 1'b1;
                    retry_n = '0;
                    timer_n = '0;
                end
            end
            ST_RUN: begin
                timer_n = timer;
                if (!lock_s) begin
                    state_n = ST_WAIT_LOCK;
                    gl0_n   = 1'b1;
                    gl1_n   = 1'b1;
                    rdy_n   = 1'b0;
                    loss_n  = sat_inc(loss);
                    timer_n = '0;
                end
            end
            ST_FAIL: begin
                timer_n = timer;
                pll_n   = 1'b1;
                gl0_n   = 1'b1;
                gl1_n   = 1'b1;
                rdy_n   = 1'b0;
                err_n   = 1'b1;
            end
            default: begin
                state_n = ST_PLL_RST;
                timer_n = '0;
                pll_n   = 1'b1;
                gl0_n   = 1'b1;
                gl1_n   = 1'b1;
                rdy_n   = 1'b0;
            end
        endcase
    end

    assign bus.PLL_RESET     = pll_q;
    assign bus.RST_GL0       = gl0_q;
    assign bus.RST_GL1       = gl1_q;
    assign bus.READY         = rdy_q;
    assign bus.TIMEOUT_ERR   = err_q;
    assign bus.LOCK_LOSS_CNT = loss;
    assign bus.STATE         = state;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with small timing parameters.
module tb_pll_lock_sequencer;
    import pll_seq_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;

    pll_lock_sequencer_if bus ();

    always #5 CLK = ~CLK;

    pll_lock_sequencer #(
        .LOCK_STABLE_CYC  (8),
        .LOCK_TIMEOUT_CYC (64),
        .REL_GAP_CYC      (4),
        .PLL_RST_CYC      (4),
        .MAX_RETRY        (2),
        .CNT_W            (16)
    ) u_dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.master)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".pll"},  bus.PLL_RESET, 1);
        chk({tag, ".gl0"},  bus.RST_GL0, 1);
        chk({tag, ".gl1"},  bus.RST_GL1, 1);
        chk({tag, ".rdy"},  bus.READY, 0);
        chk({tag, ".err"},  bus.TIMEOUT_ERR, 0);
        chk({tag, ".loss"}, bus.LOCK_LOSS_CNT, 0);
        chk({tag, ".st"},   bus.STATE, 0);
    endtask

    // reset, then run PLL_RST (4 edges) into WAIT_LOCK
    task automatic reset_to_wait();
        RST = 1'b1;
        bus.LOCK = 1'b0;
        tick(3);
        RST = 1'b0;
        tick(4);
    endtask

    // from WAIT_LOCK: 15 edges after raising LOCK reach RUN
    task automatic bring_up();
        bus.LOCK = 1'b1;
        tick(15);
    endtask

    task automatic lose();
        bus.LOCK = 1'b0;
        tick(3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.LOCK = 1'b0;
        RST = 1'b1;
        tick(3);
        chk_reset_vals("rst");
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("prst.hold", bus.PLL_RESET, 1);
            chk("prst.gl0", bus.RST_GL0, 1);
        end
        tick();
        chk("prst.end", bus.PLL_RESET, 0);
        chk("wait.st", bus.STATE, 1);
        chk("wait.rdy", bus.READY, 0);

        // clean lock
        bus.LOCK = 1'b1;
        tick(10);
        chk("clean.gl0_pre", bus.RST_GL0, 1);
        chk("clean.st_pre", bus.STATE, 2);
        tick();
        chk("clean.gl0", bus.RST_GL0, 0);
        chk("clean.rel0", bus.STATE, 3);
        chk("clean.gl1_hold", bus.RST_GL1, 1);
        tick(3);
        chk("clean.gl1_pre", bus.RST_GL1, 1);
        chk("clean.rdy_pre", bus.READY, 0);
        tick();
        chk("clean.gl1", bus.RST_GL1, 0);
        chk("clean.rdy", bus.READY, 1);
        chk("clean.run", bus.STATE, 4);
        chk("clean.loss", bus.LOCK_LOSS_CNT, 0);

        // loss in RUN
        bus.LOCK = 1'b0;
        tick(2);
        chk("loss.gl0_pre", bus.RST_GL0, 0);
        chk("loss.rdy_pre", bus.READY, 1);
        tick();
        chk("loss.gl0", bus.RST_GL0, 1);
        chk("loss.gl1", bus.RST_GL1, 1);
        chk("loss.rdy", bus.READY, 0);
        chk("loss.cnt", bus.LOCK_LOSS_CNT, 1);
        chk("loss.st", bus.STATE, 1);
        bus.LOCK = 1'b1;
        tick(10);
        chk("rest.gl0_pre", bus.RST_GL0, 1);
        tick();
        chk("rest.gl0", bus.RST_GL0, 0);
        tick(4);
        chk("rest.rdy", bus.READY, 1);
        chk("rest.gl1", bus.RST_GL1, 0);

        // unstable lock: 5 high, 1 low, then high
        reset_to_wait();
        chk("unst.st0", bus.STATE, 1);
        bus.LOCK = 1'b1;
        tick(5);
        bus.LOCK = 1'b0;
        tick();
        bus.LOCK = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("unst.hold", bus.RST_GL0, 1);
        end
        tick();
        chk("unst.gl0", bus.RST_GL0, 0);
        chk("unst.loss", bus.LOCK_LOSS_CNT, 0);

        // timeout, retry, then FAIL
        reset_to_wait();
        tick(63);
        chk("to1.st_pre", bus.STATE, 1);
        chk("to1.pll_pre", bus.PLL_RESET, 0);
        tick();
        chk("to1.st", bus.STATE, 0);
        chk("to1.pll", bus.PLL_RESET, 1);
        tick(3);
        chk("to1.prst", bus.PLL_RESET, 1);
        tick();
        chk("to1.wait", bus.STATE, 1);
        chk("to1.pll_end", bus.PLL_RESET, 0);
        tick(63);
        chk("to2.st_pre", bus.STATE, 1);
        chk("to2.err_pre", bus.TIMEOUT_ERR, 0);
        tick();
        chk("to2.fail", bus.STATE, 5);
        chk("to2.err", bus.TIMEOUT_ERR, 1);
        chk("to2.pll", bus.PLL_RESET, 1);
        bus.LOCK = 1'b1;
        tick(20);
        chk("fail.stay", bus.STATE, 5);
        chk("fail.gl0", bus.RST_GL0, 1);
        chk("fail.rdy", bus.READY, 0);
        chk("fail.err", bus.TIMEOUT_ERR, 1);

        // saturation
        reset_to_wait();
        bring_up();
        chk("sat.up", bus.READY, 1);
        for (int i = 0; i < 260; i++) begin
            lose();
            bring_up();
            if (i == 99) chk("sat.100", bus.LOCK_LOSS_CNT, 100);
        end
        chk("sat.cnt", bus.LOCK_LOSS_CNT, 255);
        chk("sat.rdy", bus.READY, 1);

        // RST while running
        RST = 1'b1;
        tick();
        chk_reset_vals("midrst");
        RST = 1'b0;
        bus.LOCK = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
